ili9341_spi_rx: RTL and testbench



---
 rtl/ili9341_spi_rx_if.sv | 30 +++
 rtl/ili9341_spi_rx.sv | 247 ++++++++++++++++++++++++
 tb/tb_ili9341_spi_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ili9341_spi_rx_if.sv
// Bundle of the ILI9341 4-wire serial lines plus the decoded command/pixel stream.
// The controller side drives the SPI lines (master); the receiver decodes them (slave).
interface ili9341_spi_rx_if #(
  parameter int COORD_W = 9
);
  logic               spi_sck;
  logic               spi_cs;
  logic               spi_mosi;
  logic               spi_dc;
  logic               cmd_valid;
  logic [7:0]         cmd_byte;
  logic               pixel_valid;
  logic [15:0]        pixel_data;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               frame_done;
  logic               window_err;

  modport master (
    output spi_sck, spi_cs, spi_mosi, spi_dc,
    input  cmd_valid, cmd_byte, pixel_valid, pixel_data,
    input  pixel_x, pixel_y, frame_done, window_err
  );

  modport slave (
    input  spi_sck, spi_cs, spi_mosi, spi_dc,
    output cmd_valid, cmd_byte, pixel_valid, pixel_data,
    output pixel_x, pixel_y, frame_done, window_err
  );
endinterface

// File: rtl/ili9341_spi_rx.sv
// ILI9341 serial-bus sniffer: oversamples SPI mode 0, assembles bytes, tracks the
// CASET/PASET window and emits RAMWR pixels as RGB565 words with coordinates.
module ili9341_spi_rx #(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int COORD_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  ili9341_spi_rx_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET_P,
    S_PASET_P,
    S_RAMWR,
    S_IGNORE
  } state_t;

  localparam logic [15:0] X_LIM = 16'(WIDTH);
  localparam logic [15:0] Y_LIM = 16'(HEIGHT);

  // Stage 0: two-flop synchronizer {sck, cs, mosi, dc} plus delayed sck for edge detect
  logic [3:0] sync_a_p0;
  logic [3:0] sync_b_p0;
  logic       sck_d_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_p0 <= 4'b0100;
      sync_b_p0 <= 4'b0100;
      sck_d_p0  <= 1'b0;
    end else begin
      sync_a_p0 <= {bus.spi_sck, bus.spi_cs, bus.spi_mosi, bus.spi_dc};
      sync_b_p0 <= sync_a_p0;
      sck_d_p0  <= sync_b_p0[3];
    end
  end

  logic sck_s, cs_s, mosi_s, dc_s, sck_rise;
  assign sck_s    = sync_b_p0[3];
  assign cs_s     = sync_b_p0[2];
  assign mosi_s   = sync_b_p0[1];
  assign dc_s     = sync_b_p0[0];
  assign sck_rise = sck_s & ~sck_d_p0 & ~cs_s;

  // Stage 1: bit shifter; a completed byte is presented for one cycle with vld_p1
  logic [6:0] shift_p1;
  logic [2:0] bit_cnt_p1;
  logic [7:0] byte_p1;
  logic       dc_p1;
  logic       vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_p1 <= 3'd0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (cs_s) begin
        bit_cnt_p1 <= 3'd0;
      end else if (sck_rise) begin
        bit_cnt_p1 <= bit_cnt_p1 + 3'd1;
        if (bit_cnt_p1 == 3'd7) vld_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sck_rise) begin
      shift_p1 <= {shift_p1[5:0], mosi_s};
      if (bit_cnt_p1 == 3'd7) begin
        byte_p1 <= {shift_p1, mosi_s};
        dc_p1   <= dc_s;
      end
    end
  end

  // Stage 2: command/parameter decoder, window tracking and pixel assembly
  state_t             state_p2, state_n;
  logic [1:0]         pidx_p2, pidx_n;
  logic [23:0]        shadow_p2, shadow_n;
  logic               half_p2, half_n;
  logic [7:0]         hi_p2, hi_n;
  logic [COORD_W-1:0] xs_p2, xe_p2, ys_p2, ye_p2;
  logic [COORD_W-1:0] xs_n, xe_n, ys_n, ye_n;
  logic [COORD_W-1:0] x_p2, y_p2, x_n, y_n;
  logic               cmd_vld_p2, cmd_vld_n;
  logic [7:0]         cmd_byte_p2, cmd_byte_n;
  logic               pix_vld_p2, pix_vld_n;
  logic [15:0]        pix_data_p2, pix_data_n;
  logic [COORD_W-1:0] pix_x_p2, pix_y_p2, pix_x_n, pix_y_n;
  logic               frame_p2, frame_n;
  logic               werr_p2, werr_n;
  logic [15:0]        win_start, win_stop;
  logic               win_ok;

  always_comb begin
    state_n    = state_p2;
    pidx_n     = pidx_p2;
    shadow_n   = shadow_p2;
    half_n     = half_p2;
    hi_n       = hi_p2;
    xs_n       = xs_p2;
    xe_n       = xe_p2;
    ys_n       = ys_p2;
    ye_n       = ye_p2;
    x_n        = x_p2;
    y_n        = y_p2;
    cmd_vld_n  = 1'b0;
    cmd_byte_n = cmd_byte_p2;
    pix_vld_n  = 1'b0;
    pix_data_n = pix_data_p2;
    pix_x_n    = pix_x_p2;
    pix_y_n    = pix_y_p2;
    frame_n    = 1'b0;
    werr_n     = 1'b0;
    // Fourth parameter byte completes the window; earlier three sit in the shadow
    win_start  = shadow_p2[23:8];
    win_stop   = {shadow_p2[7:0], byte_p1};
    win_ok     = (win_start <= win_stop);

    if (vld_p1) begin
      if (!dc_p1) begin
        cmd_vld_n  = 1'b1;
        cmd_byte_n = byte_p1;
        pidx_n     = 2'd0;
        half_n     = 1'b0;
        case (byte_p1)
          8'h2A:   state_n = S_CASET_P;
          8'h2B:   state_n = S_PASET_P;
          8'h2C: begin
            state_n = S_RAMWR;
            x_n     = xs_p2;
            y_n     = ys_p2;
          end
          default: state_n = S_IGNORE;
        endcase
      end else begin
        case (state_p2)
          S_CASET_P, S_PASET_P: begin
            shadow_n = {shadow_p2[15:0], byte_p1};
            pidx_n   = pidx_p2 + 2'd1;
            if (pidx_p2 == 2'd3) begin
              state_n = S_IGNORE;
              if (state_p2 == S_CASET_P) begin
                if (win_ok && (win_stop < X_LIM)) begin
                  xs_n = win_start[COORD_W-1:0];
                  xe_n = win_stop[COORD_W-1:0];
                end else begin
                  werr_n = 1'b1;
                end
              end else begin
                if (win_ok && (win_stop < Y_LIM)) begin
                  ys_n = win_start[COORD_W-1:0];
                  ye_n = win_stop[COORD_W-1:0];
                end else begin
                  werr_n = 1'b1;
                end
              end
            end
          end
          S_RAMWR: begin
            if (!half_p2) begin
              hi_n   = byte_p1;
              half_n = 1'b1;
            end else begin
              half_n     = 1'b0;
              pix_vld_n  = 1'b1;
              pix_data_n = {hi_p2, byte_p1};
              pix_x_n    = x_p2;
              pix_y_n    = y_p2;
              if (x_p2 == xe_p2) begin
                x_n = xs_p2;
                if (y_p2 == ye_p2) begin
                  y_n     = ys_p2;
                  frame_n = 1'b1;
                end else begin
                  y_n = y_p2 + COORD_W'(1);
                end
              end else begin
                x_n = x_p2 + COORD_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p2    <= S_IDLE;
      pidx_p2     <= 2'd0;
      half_p2     <= 1'b0;
      xs_p2       <= '0;
      xe_p2       <= COORD_W'(WIDTH - 1);
      ys_p2       <= '0;
      ye_p2       <= COORD_W'(HEIGHT - 1);
      x_p2        <= '0;
      y_p2        <= '0;
      cmd_vld_p2  <= 1'b0;
      cmd_byte_p2 <= 8'h00;
      pix_vld_p2  <= 1'b0;
      pix_data_p2 <= 16'h0000;
      pix_x_p2    <= '0;
      pix_y_p2    <= '0;
      frame_p2    <= 1'b0;
      werr_p2     <= 1'b0;
    end else begin
      state_p2    <= state_n;
      pidx_p2     <= pidx_n;
      half_p2     <= half_n;
      xs_p2       <= xs_n;
      xe_p2       <= xe_n;
      ys_p2       <= ys_n;
      ye_p2       <= ye_n;
      x_p2        <= x_n;
      y_p2        <= y_n;
      cmd_vld_p2  <= cmd_vld_n;
      cmd_byte_p2 <= cmd_byte_n;
      pix_vld_p2  <= pix_vld_n;
      pix_data_p2 <= pix_data_n;
      pix_x_p2    <= pix_x_n;
      pix_y_p2    <= pix_y_n;
      frame_p2    <= frame_n;
      werr_p2     <= werr_n;
    end
  end

  always_ff @(posedge clk) begin
    shadow_p2 <= shadow_n;
    hi_p2     <= hi_n;
  end

  assign bus.cmd_valid   = cmd_vld_p2;
  assign bus.cmd_byte    = cmd_byte_p2;
  assign bus.pixel_valid = pix_vld_p2;
  assign bus.pixel_data  = pix_data_p2;
  assign bus.pixel_x     = pix_x_p2;
  assign bus.pixel_y     = pix_y_p2;
  assign bus.frame_done  = frame_p2;
  assign bus.window_err  = werr_p2;

endmodule

// File: tb/tb_ili9341_spi_rx.sv
// Scoreboard bench for ili9341_spi_rx, run with a reduced 16x12 panel so a full
// frame fits in a short simulation.
module tb_ili9341_spi_rx;
  localparam int W  = 16;
  localparam int H  = 12;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ili9341_spi_rx_if #(.COORD_W(CW)) bus ();

  ili9341_spi_rx #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0]   d;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          fd;
  } pix_t;

  pix_t       pix_q[$];
  logic [7:0] cmd_q[$];
  int         werr_exp = 0;
  int         n_cmp    = 0;
  int         n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event
  pix_t          e_pix;
  logic [7:0]    e_cmd;
  logic [15:0]   last_d;
  logic [CW-1:0] last_x, last_y;

  always @(negedge clk) begin
    if (rst) begin
      last_d = 16'h0;
      last_x = '0;
      last_y = '0;
    end else begin
      if (bus.cmd_valid) begin
        if (cmd_q.size() == 0) unexpected("cmd_valid", 32'(bus.cmd_byte));
        else begin
          e_cmd = cmd_q.pop_front();
          chk("cmd_byte", 32'(bus.cmd_byte), 32'(e_cmd));
        end
      end
      if (bus.pixel_valid) begin
        if (pix_q.size() == 0) unexpected("pixel_valid", 32'(bus.pixel_data));
        else begin
          e_pix = pix_q.pop_front();
          chk("pixel_data", 32'(bus.pixel_data), 32'(e_pix.d));
          chk("pixel_x", 32'(bus.pixel_x), 32'(e_pix.x));
          chk("pixel_y", 32'(bus.pixel_y), 32'(e_pix.y));
          chk("frame_done", 32'(bus.frame_done), 32'(e_pix.fd));
        end
        last_d = bus.pixel_data;
        last_x = bus.pixel_x;
        last_y = bus.pixel_y;
      end else begin
        chk("pixel_hold_data", 32'(bus.pixel_data), 32'(last_d));
        chk("pixel_hold_xy", 32'({bus.pixel_x, bus.pixel_y}), 32'({last_x, last_y}));
        chk("frame_done_alone", 32'(bus.frame_done), 32'h0);
      end
      if (bus.cmd_valid && bus.pixel_valid) unexpected("cmd_with_pixel", 32'h1);
      if (bus.window_err) begin
        if (werr_exp == 0) unexpected("window_err", 32'h1);
        else begin
          n_cmp++;
          werr_exp--;
        end
      end
    end
  end

  // Stimulus: SPI mode 0, MSB first, 2-clk setup and 2-clk high phase per bit
  task automatic spi_byte(input logic dc, input logic [7:0] b, input int nbits = 8);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk);
      bus.spi_dc   = dc;
      bus.spi_mosi = b[i];
      repeat (2) @(negedge clk);
      bus.spi_sck = 1'b1;
      repeat (2) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_q.push_back(b);
    spi_byte(1'b0, b);
  endtask

  task automatic send_data(input logic [7:0] b);
    spi_byte(1'b1, b);
  endtask

  task automatic send_pix(input logic [15:0] d, input int x, input int y, input logic fd);
    pix_t p;
    p.d  = d;
    p.x  = CW'(x);
    p.y  = CW'(y);
    p.fd = fd;
    pix_q.push_back(p);
    send_data(d[15:8]);
    send_data(d[7:0]);
  endtask

  task automatic send_window(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e,
                             input logic bad);
    send_cmd(cmd);
    send_data(s[15:8]);
    send_data(s[7:0]);
    send_data(e[15:8]);
    if (bad) werr_exp++;
    send_data(e[7:0]);
  endtask

  task automatic check_reset();
    chk("rst_cmd_byte", 32'(bus.cmd_byte), 32'h0);
    chk("rst_pixel_data", 32'(bus.pixel_data), 32'h0);
    chk("rst_pixel_x", 32'(bus.pixel_x), 32'h0);
    chk("rst_pixel_y", 32'(bus.pixel_y), 32'h0);
    chk("rst_pulses", 32'({bus.cmd_valid, bus.pixel_valid, bus.frame_done, bus.window_err}), 32'h0);
  endtask

  initial begin
    bus.spi_sck  = 1'b0;
    bus.spi_cs   = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.spi_dc   = 1'b0;
    repeat (4) @(negedge clk);
    check_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);

    // Full frame in the default window
    send_cmd(8'h2C);
    for (int i = 0; i < W * H; i++) send_pix(16'hF800, i % W, i / W, i == W * H - 1);

    // Rejected windows: start > end, then end == WIDTH
    send_window(8'h2A, 16'h0010, 16'h0005, 1'b1);
    send_window(8'h2A, 16'h0000, 16'(W), 1'b1);
    send_cmd(8'h2C);
    for (int i = 0; i < 17; i++) send_pix(16'h1000 + 16'(i), i % W, i / W, 1'b0);

    // 4x2 window, ninth pixel wraps to the origin
    send_window(8'h2A, 16'h0000, 16'h0003, 1'b0);
    send_window(8'h2B, 16'h0000, 16'h0001, 1'b0);
    send_cmd(8'h2C);
    for (int i = 0; i < 9; i++) send_pix(16'h07FF, i % 4, (i / 4) % 2, i == 7);

    // Byte cut short by chip select
    spi_byte(1'b0, 8'hFF, 5);
    @(negedge clk);
    bus.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(8'h2C);
    send_pix(16'hA5C3, 0, 0, 1'b0);

    // Half pixel dropped by an intervening command
    send_cmd(8'h2C);
    send_data(8'hAB);
    send_cmd(8'h00);
    send_cmd(8'h2C);
    send_pix(16'h1234, 0, 0, 1'b0);

    // Reset in the middle of a RAMWR byte
    send_cmd(8'h2C);
    send_pix(16'h1111, 0, 0, 1'b0);
    spi_byte(1'b1, 8'h22, 3);
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    check_reset();
    send_data(8'h55);
    send_data(8'h66);
    send_cmd(8'h2C);
    for (int i = 0; i < 5; i++) send_pix(16'hBEE0 + 16'(i), i, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if (pix_q.size() == 0 && cmd_q.size() == 0 && werr_exp == 0) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("pixels_outstanding", 32'(pix_q.size()), 32'h0);
    chk("cmds_outstanding", 32'(cmd_q.size()), 32'h0);
    chk("window_err_outstanding", 32'(werr_exp), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
